// File: rtl/square34_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : square34_arbiter
// Purpose  : Round-robin arbiter sharing one external fixed-latency 34-bit
//            squarer among NUM_REQ requesters. One operand is accepted per
//            cycle. Results return in issue order, tagged by a shift register
//            that mirrors the squarer latency.
// Ports    : clk, reset (sync, active-high), pause (blocks new acceptances)
//            req_valid/req_data/req_ready  - per-requester operand handshake
//            sq_data_in/sq_data_out        - shared squarer operand/result
//            rsp_valid/rsp_data            - one-cycle result strobe + data
//            idle                          - nothing in flight or pending
//            issue_count/busy_count        - only with SQUARE34_ARB_PERF_EN
// Options  : SQUARE34_ARB_PERF_EN adds the two 32-bit performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module square34_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SQ_LAT  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*34-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [33:0]           sq_data_in,
    input  logic [67:0]           sq_data_out,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [67:0]           rsp_data,
    output logic                  idle
`ifdef SQUARE34_ARB_PERF_EN
    ,
    output logic [31:0]           issue_count,
    output logic [31:0]           busy_count
`endif
);

    localparam int             c_TAG_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_TAG_W:0] c_NUM_REQ = (c_TAG_W+1)'(NUM_REQ);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_TAG_W-1:0] r_ptr;
    logic [33:0]        r_sq_data;
    logic [SQ_LAT:0]    r_pv;                 // in-flight valid per stage
    logic [c_TAG_W-1:0] r_ptag [0:SQ_LAT];    // requester tag per stage
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [67:0]        r_rsp_data;

    // ------------------------------------------------------------------
    // Grant selection: first valid index at or after the pointer, wrapping.
    // ------------------------------------------------------------------
    logic [c_TAG_W:0]   w_sum;
    logic [c_TAG_W:0]   w_gnext;
    logic [c_TAG_W-1:0] w_gidx;
    logic [c_TAG_W-1:0] w_ptr_nxt;
    logic               w_found;
    logic               w_accept;
    logic [33:0]        w_sel_data;
    logic               w_idle;

    always_comb begin
        w_sum   = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr + k never reaches 2*NUM_REQ, so a single subtract wraps it
            w_sum = {1'b0, r_ptr} + (c_TAG_W+1)'(k);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (!w_found && req_valid[w_sum[c_TAG_W-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[c_TAG_W-1:0];
            end
        end
        w_accept = w_found && !pause && !reset;
    end

    always_comb begin
        w_gnext   = {1'b0, w_gidx} + (c_TAG_W+1)'(1);
        w_ptr_nxt = (w_gnext == c_NUM_REQ) ? '0 : w_gnext[c_TAG_W-1:0];
    end

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gidx == c_TAG_W'(k)) begin
                w_sel_data = req_data[k*34 +: 34];
            end
        end
    end

    assign req_ready = w_accept ? (NUM_REQ'(1) << w_gidx) : '0;

    // ------------------------------------------------------------------
    // Issue register, in-flight tracking and response register.
    // Stage k of r_pv is valid k+1 cycles after acceptance; the last stage
    // lines up with sq_data_out for that operand.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_sq_data   <= '0;
            r_pv        <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_ptr     <= w_ptr_nxt;
                r_sq_data <= w_sel_data;
            end
            r_pv[0] <= w_accept;
            for (int k = 1; k <= SQ_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
            end
            r_rsp_valid <= r_pv[SQ_LAT] ? (NUM_REQ'(1) << r_ptag[SQ_LAT]) : '0;
            if (r_pv[SQ_LAT]) begin
                r_rsp_data <= sq_data_out;
            end
        end
    end

    // Tags carry no meaning without their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        r_ptag[0] <= w_gidx;
        for (int k = 1; k <= SQ_LAT; k++) begin
            r_ptag[k] <= r_ptag[k-1];
        end
    end

    assign w_idle     = (r_pv == '0) && (r_rsp_valid == '0);
    assign idle       = w_idle;
    assign sq_data_in = r_sq_data;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;

`ifdef SQUARE34_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] r_issue_cnt;
    logic [31:0] r_busy_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_cnt <= '0;
            r_busy_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
            if (!w_idle) begin
                r_busy_cnt <= r_busy_cnt + 32'd1;
            end
        end
    end

    assign issue_count = r_issue_cnt;
    assign busy_count  = r_busy_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_square34_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_square34_arbiter
// Purpose  : Self-checking bench for square34_arbiter (NUM_REQ=4, SQ_LAT=3).
//            Directed vectors with hand-computed grants; expected responses
//            go into a scoreboard queue and a monitor compares them when
//            rsp_valid is seen. The external squarer is modelled here.
// Options  : define SQUARE34_ARB_PERF_EN to exercise the perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_square34_arbiter;

    localparam int c_N   = 4;
    localparam int c_LAT = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            pause;
    logic [3:0]      req_valid;
    logic [135:0]    req_data;
    logic [3:0]      req_ready;
    logic [33:0]     sq_data_in;
    logic [67:0]     sq_data_out;
    logic [3:0]      rsp_valid;
    logic [67:0]     rsp_data;
    logic            idle;
`ifdef SQUARE34_ARB_PERF_EN
    logic [31:0]     issue_count;
    logic [31:0]     busy_count;
`endif

    square34_arbiter #(.NUM_REQ(c_N), .SQ_LAT(c_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .sq_data_in (sq_data_in),
        .sq_data_out(sq_data_out),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .idle       (idle)
`ifdef SQUARE34_ARB_PERF_EN
        ,
        .issue_count(issue_count),
        .busy_count (busy_count)
`endif
    );

    always #5 clk = ~clk;

    // External squarer: result visible c_LAT cycles after the operand.
    logic [67:0] sqp [0:c_LAT-1];
    always @(posedge clk) begin
        sqp[0] <= 68'(sq_data_in) * 68'(sq_data_in);
        for (int i = 1; i < c_LAT; i++) sqp[i] <= sqp[i-1];
    end
    assign sq_data_out = sqp[c_LAT-1];

    logic [33:0] dat [0:3];
    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  v;
        logic [67:0] d;
        int          c;
    } exp_t;
    exp_t sb [$];

    int          errors    = 0;
    int          checks    = 0;
    int          rsp_seen  = 0;
    int          last_acc  = 0;
    int          last_cyc  = 0;
    logic [67:0] last_data = '0;
    int          tb_busy   = 0;
    int          tb_issue  = 0;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT strobes a response.
    always @(negedge clk) begin
        if (rsp_valid != 4'b0) begin
            exp_t e;
            rsp_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b with nothing expected (cycle %0d)",
                         rsp_valid, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", 68'(rsp_valid), 68'(e.v));
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_cycle", 68'(cyc), 68'(e.c));
                last_cyc  = cyc;
                last_data = rsp_data;
            end
        end
    end

    // One clock cycle of stimulus with a hand-computed expected grant.
    task automatic step(input logic [3:0] v, input logic p, input logic [3:0] exp_rdy);
        exp_t e;
        logic [33:0] d;
        req_valid = v;
        pause     = p;
        @(negedge clk);
        chk("req_ready", 68'(req_ready), 68'(exp_rdy));
        if (!idle) tb_busy++;
        d = '0;
        if (exp_rdy != 4'b0) begin
            for (int i = 0; i < 4; i++) if (exp_rdy[i]) d = dat[i];
            e.v = exp_rdy;
            e.d = 68'(d) * 68'(d);
            e.c = cyc + c_LAT + 2;
            sb.push_back(e);
            last_acc = cyc;
            tb_issue++;
        end
        @(posedge clk);
        #1;
        if (exp_rdy != 4'b0) chk("sq_data_in", 68'(sq_data_in), 68'(d));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'hF;
        pause     = 1'b0;
        @(negedge clk);
        chk("ready_in_reset", 68'(req_ready), 68'h0);
        sb.delete();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        req_valid = 4'h0;
        tb_busy  = 0;
        tb_issue = 0;
        chk("rst_idle", 68'(idle), 68'h1);
        chk("rst_rsp_valid", 68'(rsp_valid), 68'h0);
        chk("rst_sq_data_in", 68'(sq_data_in), 68'h0);
        chk("rst_rsp_data", rsp_data, 68'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (sb.size() != 0 || !idle); i++) step(4'h0, 1'b0, 4'h0);
        chk("drain_done", {66'h0, sb.size() == 0, idle}, 68'h3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0;
        reset     = 1'b1;
        pause     = 1'b0;
        req_valid = 4'h0;
        dat[0]    = 34'h0_0000_0003;
        dat[1]    = 34'h1_2345_6789;
        dat[2]    = 34'h3_FFFF_FFFF;
        dat[3]    = 34'h2_0000_0001;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single requester 2, all-ones operand; result 5 cycles later.
        step(4'b0100, 1'b0, 4'b0100);
        chk("busy_after_issue", 68'(idle), 68'h0);
        drain();
        chk("rsp31_cycle", 68'(last_cyc), 68'(last_acc + 5));
        chk("rsp31_data", last_data, 68'hF_FFFF_FFF8_0000_0001);
        chk("rsp_data_hold", rsp_data, 68'hF_FFFF_FFF8_0000_0001);
        chk("sq_data_in_hold", 68'(sq_data_in), 68'h3_FFFF_FFFF);

        // Pointer now 3: only 0 and 1 valid -> wrap to 0, then 1.
        step(4'b0011, 1'b0, 4'b0001);
        step(4'b0011, 1'b0, 4'b0010);
        drain();

        // All valid continuously from reset release: 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < 8; i++) step(4'hF, 1'b0, 4'(1 << (i % 4)));
        drain();

        // Three in flight, then pause for 4 cycles; responses still drain.
        step(4'hF, 1'b0, 4'b0001);
        step(4'hF, 1'b0, 4'b0010);
        step(4'hF, 1'b0, 4'b0100);
        step(4'hF, 1'b1, 4'b0000);
        step(4'hF, 1'b1, 4'b0000);
        chk("busy_in_pause", 68'(idle), 68'h0);
        step(4'hF, 1'b1, 4'b0000);
        step(4'hF, 1'b1, 4'b0000);
        drain();
        step(4'hF, 1'b0, 4'b1000);   // pointer held at 3 across the pause
        drain();

        // Reset two cycles after two acceptances discards them.
        do_reset();
        step(4'b0011, 1'b0, 4'b0001);
        step(4'b0011, 1'b0, 4'b0010);
        step(4'b0000, 1'b0, 4'b0000);
        step(4'b0000, 1'b0, 4'b0000);
        do_reset();
        seen0 = rsp_seen;
        for (int i = 0; i < 10; i++) step(4'h0, 1'b0, 4'h0);
        chk("no_rsp_after_reset", 68'(rsp_seen - seen0), 68'h0);
        chk("idle_after_reset", 68'(idle), 68'h1);
        step(4'hF, 1'b0, 4'b0001);   // pointer back at 0
        drain();

`ifdef SQUARE34_ARB_PERF_EN
        // 7 acceptances over 12 cycles.
        do_reset();
        begin
            logic [11:0] pat;
            pat = 12'b0101_0110_1011;
            for (int i = 0; i < 12; i++)
                step(pat[i] ? 4'b0001 : 4'b0000, 1'b0, pat[i] ? 4'b0001 : 4'b0000);
        end
        chk("issue_count", 68'(issue_count), 68'd7);
        chk("issue_model", 68'(tb_issue), 68'd7);
        chk("busy_count_mid", 68'(busy_count), 68'(tb_busy));
        drain();
        chk("busy_count_end", 68'(busy_count), 68'(tb_busy));
`endif

        chk("sb_empty", 68'(sb.size()), 68'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/square34_arbiter.md
SQUARE34_ARBITER -- requirements
Module: square34_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter SQ_LAT, default 3, fixed latency in cycles of the shared external 34-bit squarer, sq_data_in to sq_data_out (0..8).
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port pause, input, 1: when high, no new request is accepted.
REQ-006 SHALL have port req_valid, input, NUM_REQ: per-requester operand valid.
REQ-007 SHALL have port req_data, input, NUM_REQ*34: per-requester operand, requester i in bits [34*i+33:34*i].
REQ-008 SHALL have port req_ready, output, NUM_REQ: one-hot or zero grant.
REQ-009 SHALL have port sq_data_in, output, 34: registered operand to the shared squarer.
REQ-010 SHALL have port sq_data_out, input, 68: squarer result, valid SQ_LAT cycles after sq_data_in.
REQ-011 SHALL have port rsp_valid, output, NUM_REQ: one-cycle result strobe per requester.
REQ-012 SHALL have port rsp_data, output, 68: registered result, shared by all requesters.
REQ-013 SHALL have port idle, output, 1: high when nothing is in flight and no response is pending.

Function
REQ-014 SHALL compute req_ready combinationally from req_valid, pause and the round-robin pointer; req_ready SHALL be zero when pause=1 or req_valid=0.
REQ-015 SHALL grant at most one requester per cycle: the first valid index at or after the pointer, wrapping modulo NUM_REQ.
REQ-016 SHALL, on acceptance of index g, set the pointer to (g+1) mod NUM_REQ; with no acceptance, the pointer SHALL hold.
REQ-017 SHALL, on acceptance in cycle t, load req_data of g into sq_data_in at the end of cycle t; otherwise sq_data_in SHALL hold its value.
REQ-018 SHALL track in-flight issues with a SQ_LAT+1 deep shift register of {valid, tag}, where tag is ceil(log2(NUM_REQ)) bits wide.
REQ-019 SHALL register sq_data_out into rsp_data and pulse rsp_valid[tag] at cycle t+SQ_LAT+2 for acceptance in cycle t.
REQ-020 SHALL never stall responses; requesters SHALL accept rsp_valid unconditionally.
REQ-021 SHALL support back-to-back acceptances at a throughput of one per cycle, with responses in issue order.
REQ-022 SHALL make idle = no valid stage in the shift register and rsp_valid=0.
REQ-023 SHALL continue to drain in-flight work while pause=1.
REQ-024 SHALL keep rsp_data unchanged in cycles where rsp_valid=0.

Reset
REQ-025 SHALL, with reset=1 at a clock edge, clear the pointer to 0, all shift-register valids, sq_data_in, rsp_valid and rsp_data to 0, and set idle to 1.
REQ-026 SHALL discard in-flight operations on reset mid-operation: no rsp_valid for them, ever.
REQ-027 SHALL drive req_ready to 0 while reset=1.

Configuration
REQ-028 SHALL, with macro SQUARE34_ARB_PERF_EN defined, add an output issue_count (32 bits) that increments per acceptance, wraps at 2^32 and clears on reset.
REQ-029 SHALL, with SQUARE34_ARB_PERF_EN defined, also add an output busy_count (32 bits) that increments each cycle idle=0 and wraps at 2^32.
REQ-030 SHALL, without SQUARE34_ARB_PERF_EN, omit both ports and counters, with all other behaviour identical.

Verification
REQ-031 SHALL cover: NUM_REQ=4, SQ_LAT=3, only req 2 valid with data 0x3_FFFF_FFFF in cycle 5 -> req_ready=4'b0100 in cycle 5, rsp_valid=4'b0100 and rsp_data=0xF_FFFF_FFF8_0000_0001 in cycle 10.
REQ-032 SHALL cover: all four requesters valid continuously from reset release -> grants 0,1,2,3,0,… one per cycle, responses in that order 5 cycles after each grant.
REQ-033 SHALL cover: pointer at 3, only reqs 0 and 1 valid -> grant 0 (wrap), then 1.
REQ-034 SHALL cover: pause=1 for 4 cycles while all are valid, with 3 in flight -> req_ready=0, the 3 responses still delivered, idle=1 once drained.
REQ-035 SHALL cover: reset asserted 2 cycles after 2 acceptances -> no rsp_valid in the following 10 cycles, pointer=0, idle=1.
REQ-036 SHALL cover: with SQUARE34_ARB_PERF_EN defined, 7 acceptances over 12 cycles -> issue_count=7, and busy_count equals the number of cycles with idle=0.
